// File: rtl/output_giver.sv
// Parallel-to-serial output stage: captures one W-bit word and emits it as
// N-bit chunks MSB-first under valid/ready flow control, then pulses done.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SEND  | presenting sreg top chunk; shifts on each accepted transfer
// DONE  | one-cycle done pulse, then back to IDLE
module output_giver #(
   parameter int N = 4,
   parameter int W = 32,
   parameter int C = W / N
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] data_in,
   input  logic         start,
   input  logic         out_ready,
   output logic [N-1:0] Ciphertxt,
   output logic         out_valid,
   output logic         busy,
   output logic         done
);

   localparam int CW = (C > 1) ? $clog2(C) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(C - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  sreg_q, sreg_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // out_valid is high throughout SEND, so out_ready alone marks a transfer there
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sreg_d  = data_in;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  sreg_d = sreg_q << N;
                  cnt_d  = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // outputs depend on registers only
   always_comb begin
      Ciphertxt = '0;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         SEND: begin
            Ciphertxt = sreg_q[W-1 -: N];
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            Ciphertxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_output_giver.sv
// Directed bench for output_giver: basic word, backpressure, start while busy,
// reset mid-word, back-to-back words and reset colliding with start.
module tb_output_giver;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_in;
   logic        start;
   logic        out_ready;
   logic [3:0]  Ciphertxt;
   logic        out_valid;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_err = 0;

   output_giver #(.N(4), .W(32), .C(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .start     (start),
      .out_ready (out_ready),
      .Ciphertxt (Ciphertxt),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_data"},  {28'd0, Ciphertxt}, 32'd0);
      check({tag, "_busy"},  {31'd0, busy},      32'd0);
      check({tag, "_done"},  {31'd0, done},      32'd0);
   endtask

   function automatic logic [3:0] nib(input logic [31:0] w, input int i);
      logic [31:0] s;
      s = w >> (28 - 4 * i);
      return s[3:0];
   endfunction

   // Loads exp, then drains it. Stalls stall_len cycles while beat stall_beat
   // is presented. poke pulses start (0x99999999) in SEND and in DONE.
   task automatic run_word(input string tag, input logic [31:0] exp,
                           input int stall_beat, input int stall_len, input bit poke);
      int xfers = 0;
      int stalled = 0;
      int cycles = 0;
      bit finished = 0;
      data_in = exp;
      start = 1'b1;
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      while (!finished && cycles < 40) begin
         cycles++;
         if (poke) begin
            start   = (xfers == 3);
            data_in = 32'h9999_9999;
         end
         if (done) begin
            check({tag, "_xfers_at_done"}, xfers, 8);
            check({tag, "_done_cycle"}, cycles, 9 + stall_len);
            check({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
            check({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
            start = poke;
            finished = 1;
         end else if (out_valid) begin
            if (xfers == stall_beat && stalled < stall_len) begin
               out_ready = 1'b0;
               stalled++;
            end else begin
               out_ready = 1'b1;
            end
            check($sformatf("%s_beat%0d", tag, xfers), {28'd0, Ciphertxt}, {28'd0, nib(exp, xfers)});
            if (out_ready) xfers++;
         end
         tick();
      end
      if (!finished) check({tag, "_timeout"}, 32'd0, 32'd1);
      start = 1'b0;
      out_ready = 1'b1;
      check_idle({tag, "_after"});
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      data_in = '0;
      out_ready = 1'b1;
      tick();
      tick();
      check_idle("reset");
      reset = 1'b0;
      tick();

      // 1: basic word
      run_word("basic", 32'h1234_ABCD, -1, 0, 0);
      tick();

      // 2: backpressure, three stalled cycles on beat 2 (0xA)
      run_word("bp", 32'hDEAD_BEEF, 2, 3, 0);
      tick();

      // 3: start while busy is ignored
      run_word("busy_start", 32'h1111_1111, -1, 0, 1);
      tick();
      check("busy_start_no_reload", {31'd0, out_valid}, 32'd0);

      // 4: reset after the 4th transfer
      data_in = 32'hCAFE_F00D;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_mid_beat%0d", i), {28'd0, Ciphertxt}, {28'd0, nib(32'hCAFE_F00D, i)});
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle("rst_mid");
      begin
         int seen_done = 0;
         for (int i = 0; i < 12; i++) begin
            if (done || out_valid) seen_done++;
            tick();
         end
         check("rst_mid_quiet", seen_done, 0);
      end
      run_word("post_rst", 32'h0000_0001, -1, 0, 0);
      tick();

      // 5: back-to-back with start held high
      data_in = 32'hFFFF_FFFF;
      start = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         data_in = 32'h8000_0000;
         check($sformatf("b2b_w0_beat%0d", i), {27'd0, out_valid, Ciphertxt}, 32'h1F);
         tick();
      end
      check("b2b_w0_done", {31'd0, done}, 32'd1);
      tick();
      check("b2b_idle_busy", {30'd0, busy, out_valid}, 32'd0);
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("b2b_w1_beat%0d", i), {27'd0, out_valid, Ciphertxt},
               {27'd0, 1'b1, nib(32'h8000_0000, i)});
         tick();
      end
      check("b2b_w1_done", {31'd0, done}, 32'd1);
      tick();
      check_idle("b2b_end");

      // 6: reset and start on the same edge
      data_in = 32'h5555_5555;
      start = 1'b1;
      reset = 1'b1;
      tick();
      start = 1'b0;
      reset = 1'b0;
      check_idle("rst_start");
      tick();
      check("rst_start_still_idle", {30'd0, busy, out_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
